uart_frame_loader: RTL

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

---
 rtl/uart_frame_loader_pkg.sv | 35 +++
 rtl/ufl_byte_packer.sv | 42 ++++
 rtl/uart_frame_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the UART instruction-memory frame loader.
// Holds the FSM state encoding, frame field widths, the default start-of-frame
// byte and the packed write-port payload used between the FSM and the outputs.
package uart_frame_loader_pkg;

  localparam int unsigned UFL_BYTE_W = 8;
  localparam int unsigned UFL_WORD_W = 32;
  localparam int unsigned UFL_LEN_W  = 16;
  localparam int unsigned UFL_CSUM_W = 8;

  localparam logic [UFL_BYTE_W-1:0] UFL_SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } ufl_state_e;

  // Instruction-memory write port payload.
  typedef struct packed {
    logic                  we;
    logic [UFL_WORD_W-1:0] wa;
    logic [UFL_WORD_W-1:0] wd;
  } ufl_wr_t;

  // True while a frame is being received (CPU fetch held in reset).
  function automatic logic ufl_in_frame(input ufl_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/ufl_byte_packer.sv
// Assembles four consecutive payload bytes into a little-endian 32-bit word.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   clear         - synchronous flush of any partial word
//   push, byte_in - byte strobe and data
//   word_c        - assembled word including the byte being pushed (combinational)
//   word_ready_c  - high when the current push is the 4th byte of a word
module ufl_byte_packer
  import uart_frame_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [UFL_BYTE_W-1:0] byte_in,
  output logic [UFL_WORD_W-1:0] word_c,
  output logic                  word_ready_c
);

  localparam int unsigned SH_W = UFL_WORD_W - UFL_BYTE_W;

  logic [SH_W-1:0] shreg;
  logic [1:0]      cnt;

  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (push) begin
      shreg <= {byte_in, shreg[SH_W-1:UFL_BYTE_W]};
      cnt   <= cnt + 2'd1;
    end
  end

  assign word_c       = {byte_in, shreg};
  assign word_ready_c = push && (cnt == 2'd3);

endmodule

// File: rtl/uart_frame_loader.sv
// Loads a framed program image received over UART into instruction memory.
// Frame: SOF, LEN_LO, LEN_HI (word count N), N*4 little-endian payload bytes,
// plus a trailing XOR checksum byte when UFL_CHECKSUM_EN is defined.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   enable         - load mode; dropping it aborts and clears status
//   uart_v, uart_d - received byte strobe and data
//   we, wa, wd     - one-cycle instruction-memory write (word address, data)
//   imRst          - high while a frame is in progress
//   done, err      - sticky frame success / rejection flags
// Build option: UFL_CHECKSUM_EN adds the CSUM state and payload XOR check.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int unsigned          ADDR_W = 6,
  parameter logic [UFL_BYTE_W-1:0] SOF   = UFL_SOF_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  uart_v,
  input  logic [UFL_BYTE_W-1:0] uart_d,
  output logic                  we,
  output logic [UFL_WORD_W-1:0] wa,
  output logic [UFL_WORD_W-1:0] wd,
  output logic                  imRst,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CAP   = 32'(1) << ADDR_W;

`ifdef UFL_CHECKSUM_EN
  localparam ufl_state_e FRAME_END = ST_CSUM;
`else
  localparam ufl_state_e FRAME_END = ST_DONE;
`endif

  ufl_state_e state, next_state;

  logic [UFL_BYTE_W-1:0] len_lo;
  logic [UFL_LEN_W-1:0]  len;
  logic [CNT_W-1:0]      wcnt;
  ufl_wr_t               wr, wr_nxt;
  logic                  imrst_nxt, done_nxt, err_nxt;

  logic                  accept_c;
  logic [UFL_LEN_W-1:0]  len_rx_c;
  logic                  len_over_c, len_zero_c, last_word_c;
  logic                  push_c, clear_c;
  logic [UFL_WORD_W-1:0] word_c;
  logic                  word_ready_c;

  // A byte only counts while load mode is active; enable loss drops it.
  assign accept_c    = enable && uart_v;
  assign len_rx_c    = {uart_d, len_lo};
  assign len_over_c  = 32'(len_rx_c) > CAP;
  assign len_zero_c  = (len_rx_c == '0);
  assign last_word_c = (32'(wcnt) + 32'd1) == 32'(len);
  assign push_c      = accept_c && (state == ST_DATA);
  assign clear_c     = !enable || (state != ST_DATA);

`ifdef UFL_CHECKSUM_EN
  logic [UFL_CSUM_W-1:0] csum;
  logic                  csum_ok_c;
  assign csum_ok_c = (uart_d == csum);
`endif

  ufl_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear_c),
    .push         (push_c),
    .byte_in      (uart_d),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: advances only on accepted bytes, except enable loss.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = ST_IDLE;
    end else if (uart_v) begin
      case (state)
        ST_IDLE: if (uart_d == SOF) next_state = ST_LEN0;
        ST_LEN0: next_state = ST_LEN1;
        ST_LEN1: begin
          if (len_over_c)      next_state = ST_ERR;
          else if (len_zero_c) next_state = FRAME_END;
          else                 next_state = ST_DATA;
        end
        ST_DATA: if (word_ready_c && last_word_c) next_state = FRAME_END;
`ifdef UFL_CHECKSUM_EN
        ST_CSUM: next_state = csum_ok_c ? ST_DONE : ST_ERR;
`endif
        default: next_state = state;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    wr_nxt    = wr;
    wr_nxt.we = 1'b0;
    if (push_c && word_ready_c) begin
      wr_nxt.we = 1'b1;
      wr_nxt.wa = UFL_WORD_W'(wcnt[ADDR_W-1:0]);
      wr_nxt.wd = word_c;
    end
    imrst_nxt = ufl_in_frame(next_state);
    done_nxt  = (next_state == ST_DONE);
    err_nxt   = (next_state == ST_ERR);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr    <= '0;
      imRst <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      wr    <= wr_nxt;
      imRst <= imrst_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  assign we = wr.we;
  assign wa = wr.wa;
  assign wd = wr.wd;

  // Frame datapath: length capture, word counter and checksum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo <= '0;
      len    <= '0;
      wcnt   <= '0;
`ifdef UFL_CHECKSUM_EN
      csum   <= '0;
`endif
    end else if (accept_c) begin
      case (state)
        ST_LEN0: len_lo <= uart_d;
        ST_LEN1: begin
          len  <= len_rx_c;
          wcnt <= '0;
`ifdef UFL_CHECKSUM_EN
          csum <= '0;
`endif
        end
        ST_DATA: begin
`ifdef UFL_CHECKSUM_EN
          csum <= csum ^ uart_d;
`endif
          if (word_ready_c) wcnt <= wcnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
